// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op codes, FSM state
// encoding and default latencies. Also imported by the decode controller.
package mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit signed/unsigned divider. Quotient truncates toward
// zero, remainder takes the dividend's sign. Divide-by-zero returns an
// all-ones quotient and the dividend as remainder; the signed overflow case
// 0x80000000 / -1 returns 0x80000000 with zero remainder.
module mdu_div_core (
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    // Divide magnitudes, then restore signs and apply the special cases.
    always_comb begin
        a_neg_s = signed_i & dividend_i[31];
        b_neg_s = signed_i & divisor_i[31];
        a_mag_s = a_neg_s ? (32'd0 - dividend_i) : dividend_i;
        b_mag_s = b_neg_s ? (32'd0 - divisor_i) : divisor_i;
        if (b_mag_s != 32'd0) begin
            q_mag_s = a_mag_s / b_mag_s;
            r_mag_s = a_mag_s % b_mag_s;
        end else begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end
        if (divisor_i == 32'd0) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = dividend_i;
        end else if (signed_i && (dividend_i == 32'h8000_0000) &&
                     (divisor_i == 32'hFFFF_FFFF)) begin
            quot_o = 32'h8000_0000;
            rem_o  = 32'd0;
        end else begin
            quot_o = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
            rem_o  = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
// Results are computed on the accepting edge into pending registers and
// committed to HI/LO after MULT_LAT / DIV_LAT edges; busy is high meanwhile.
// Build option: define MDU_DIV_EN to implement div/divu (instantiates
// mdu_div_core); without it div/divu are no-ops and no divider exists.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HIO,
    output logic [31:0] LOO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             busy_q;

    logic             mult_signed_d;
    logic [63:0]      prod_d;

    // 64-bit product on sign- or zero-extended operands.
    always_comb begin
        mult_signed_d = (md_op == MD_MULT);
        if (mult_signed_d) begin
            prod_d = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else begin
            prod_d = {32'd0, A} * {32'd0, B};
        end
    end

`ifdef MDU_DIV_EN
    logic        div_signed_d;
    logic [31:0] div_quot_d;
    logic [31:0] div_rem_d;

    assign div_signed_d = (md_op == MD_DIV);

    mdu_div_core u_div_core (
        .dividend_i (A),
        .divisor_i  (B),
        .signed_i   (div_signed_d),
        .quot_o     (div_quot_d),
        .rem_o      (div_rem_d)
    );
`endif

    // Control FSM: accept requests in IDLE, count down in BUSY, commit on last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                pend_hi_q <= prod_d[63:32];
                                pend_lo_q <= prod_d[31:0];
                                cnt_q     <= CNT_W'(MULT_LAT);
                                state_q   <= S_BUSY;
                                busy_q    <= 1'b1;
                            end
`ifdef MDU_DIV_EN
                            MD_DIV, MD_DIVU: begin
                                pend_hi_q <= div_rem_d;
                                pend_lo_q <= div_quot_d;
                                cnt_q     <= CNT_W'(DIV_LAT);
                                state_q   <= S_BUSY;
                                busy_q    <= 1'b1;
                            end
`endif
                            MD_MTHI: hi_q <= A;
                            MD_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HIO  = hi_q;
    assign LOO  = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit. A transaction-level model
// (arithmetic on whole operations plus a commit cycle number) is compared
// against busy/HIO/LOO every cycle; hand-computed literals pin key results.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MLAT = 5;
    localparam int DLAT = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HIO;
    logic [31:0] LOO;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HIO   (HIO),
        .LOO   (LOO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

`ifdef MDU_DIV_EN
    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return {32'd0, 32'h8000_0000};
            sa = int'(a);
            sb = int'(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction
`endif

    // Transaction model: result known at acceptance, visible from cycle accept+LAT.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pend;
    int unsigned cyc, m_commit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_phi <= 32'd0; m_plo <= 32'd0;
            m_pend <= 1'b0; cyc <= 0; m_commit <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_pend) begin
                if (cyc == m_commit) begin
                    m_hi <= m_phi; m_lo <= m_plo; m_pend <= 1'b0;
                end
            end else if (start) begin
                case (md_op)
                    MD_MULT, MD_MULTU: begin
                        {m_phi, m_plo} <= model_mult(md_op == MD_MULT, A, B);
                        m_pend <= 1'b1;
                        m_commit <= cyc + MLAT;
                    end
`ifdef MDU_DIV_EN
                    MD_DIV, MD_DIVU: begin
                        {m_phi, m_plo} <= model_div(md_op == MD_DIV, A, B);
                        m_pend <= 1'b1;
                        m_commit <= cyc + DLAT;
                    end
`endif
                    MD_MTHI: m_hi <= A;
                    MD_MTLO: m_lo <= A;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_pend});
            check("cyc_HIO", HIO, m_hi);
            check("cyc_LOO", LOO, m_lo);
        end
    end

    // Present a request for one cycle; operands are scrambled afterwards.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    endtask

    // Count busy cycles until idle, bounded.
    task automatic wait_idle(output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (!done) begin
                @(negedge clk);
                if (busy === 1'b0) done = 1'b1;
                else n++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%b after 60 cycles, required 0", busy);
        end
    endtask

    task automatic div_case(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi_en, input logic [31:0] lo_en);
        int          n;
        logic [31:0] hi_old;
        logic [31:0] lo_old;
        hi_old = HIO; lo_old = LOO;
        issue(op, a, b);
        wait_idle(n);
        check({name, "_busy"}, 32'(n), DIV_ON ? 32'd10 : 32'd0);
        check({name, "_hi"}, HIO, DIV_ON ? hi_en : hi_old);
        check({name, "_lo"}, LOO, DIV_ON ? lo_en : lo_old);
    endtask

    initial begin
        int n;
        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HIO, 32'd0);
        check("rst_lo", LOO, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        check("mult_busy", 32'(n), 32'd5);
        check("mult_hi", HIO, 32'hFFFF_FFFF);
        check("mult_lo", LOO, 32'hFFFF_FFFE);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        check("multu_busy", 32'(n), 32'd5);
        check("multu_hi", HIO, 32'h0000_0001);
        check("multu_lo", LOO, 32'hFFFF_FFFE);

        // mthi during busy must be dropped
        issue(MD_MULT, 32'd3, 32'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        wait_idle(n);
        check("ign_busy", 32'(n), 32'd2);
        check("ign_hi", HIO, 32'd0);
        check("ign_lo", LOO, 32'd15);

        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", HIO, 32'h0000_1234);
        issue(MD_MTLO, 32'h0000_5678, 32'd0);
        @(negedge clk);
        check("mtlo_lo", LOO, 32'h0000_5678);
        check("mtlo_hi", HIO, 32'h0000_1234);

        issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle(n);
        check("mult_min_hi", HIO, 32'h4000_0000);
        check("mult_min_lo", LOO, 32'd0);
        issue(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle(n);
        issue(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle(n);
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        issue(MD_MTLO, 32'h0000_5678, 32'd0);

        div_case("div10_3", MD_DIV, 32'd10, 32'd3, 32'd1, 32'd3);
        div_case("div_neg7", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        div_case("divu_by0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        div_case("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        div_case("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);

        // Back-to-back: div accepted on the first idle cycle after a mult
        issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
        wait_idle(n);
        check("b2b_mult_busy", 32'(n), 32'd5);
        issue(MD_DIVU, 32'd100, 32'd7);
        check("b2b_mid_hi", HIO, 32'd1);
        check("b2b_mid_lo", LOO, 32'd0);
        wait_idle(n);
        check("b2b_div_busy", 32'(n), DIV_ON ? 32'd10 : 32'd0);
        check("b2b_hi", HIO, DIV_ON ? 32'd2 : 32'd1);
        check("b2b_lo", LOO, DIV_ON ? 32'd14 : 32'd0);

        // Reset during a divide: nothing commits afterwards
        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HIO, 32'd0);
        check("abort_lo", LOO, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", HIO, 32'd0);
        check("abort_late_lo", LOO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
